mem_loader: RTL and testbench

- Byte-stream bus initiator that loads program/data images into the 16-bit block RAM over its single-port bus: o_mem_cyc, o_mem_we, o_mem_addr, o_mem_dat, with i_mem_dat as combinational read data.
- Sits between a byte source (UART receiver, debug link) and the memory port. Parses a framed image and writes it word by word.
- After writing, reads the region back and checks a 16-bit checksum.

---
 rtl/mem_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: byte-stream bus initiator that loads a framed image into a
// 16-bit single-port RAM, then reads the region back and checks a 16-bit sum.
//
// Frame: A5, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, N x (LO, HI), SUM_LO, SUM_HI
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_rx_dat    incoming byte
//   i_rx_valid  i_rx_dat is valid
//   o_rx_ready  byte accepted this cycle when valid & ready
//   o_mem_cyc   bus cycle active
//   o_mem_we    write strobe (only with o_mem_cyc)
//   o_mem_addr  word address (holds last bus address when idle)
//   o_mem_dat   write data (holds last assembled word when idle)
//   i_mem_dat   combinational read data
//   o_busy      loader is inside a frame
//   o_done      one-cycle pulse at the end of each frame
//   o_err       checksum/readback failure, sticky until the next sync byte
module mem_loader #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_dat,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic          o_mem_cyc,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [15:0]   o_mem_dat,
  input  logic [15:0]   i_mem_dat,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA_LO, DATA_HI, WRITE, SUM, VERIFY, RESULT
  } state_e;

  localparam logic [7:0] SYNC = 8'hA5;

  state_e        state_q, state_d;
  logic [1:0]    byteIdx_q, byteIdx_d;
  logic [7:0]    lowByte_q, lowByte_d;
  logic [AW-1:0] startAddr_q, startAddr_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] lastAddr_q, lastAddr_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   remain_q, remain_d;
  logic [15:0]   word_q, word_d;
  logic [15:0]   wSum_q, wSum_d;
  logic [15:0]   rSum_q, rSum_d;
  logic [15:0]   rxSum_q, rxSum_d;
  logic          err_q, err_d;

  logic          take;
  logic          sumBad;
  logic [15:0]   rxWord;

  assign take   = i_rx_valid & o_rx_ready;
  // Every 16-bit field arrives low byte first; the low byte is parked in lowByte_q.
  assign rxWord = {i_rx_dat, lowByte_q};
  assign sumBad = (rxSum_q != wSum_q) || (rSum_q != wSum_q);

  // o_mem_dat is the assembled word register itself, so it naturally holds
  // the last written word between bus cycles.
  assign o_mem_dat = word_q;

  // Outputs are decoded from the state; strobes are masked while reset is
  // asserted so an abort never produces a further bus cycle or done pulse.
  always_comb begin
    o_rx_ready = 1'b0;
    o_mem_cyc  = 1'b0;
    o_mem_we   = 1'b0;
    o_mem_addr = lastAddr_q;
    o_done     = 1'b0;
    o_busy     = (state_q != IDLE);
    o_err      = err_q;
    case (state_q)
      IDLE, HDR, DATA_LO, DATA_HI, SUM: o_rx_ready = ~i_reset;
      WRITE: begin
        o_mem_cyc  = ~i_reset;
        o_mem_we   = ~i_reset;
        o_mem_addr = ptr_q;
      end
      VERIFY: begin
        o_mem_cyc  = ~i_reset;
        o_mem_addr = ptr_q;
      end
      RESULT: begin
        o_done = ~i_reset;
        o_err  = err_q | (sumBad & ~i_reset);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    byteIdx_d   = byteIdx_q;
    lowByte_d   = lowByte_q;
    startAddr_d = startAddr_q;
    ptr_d       = ptr_q;
    lastAddr_d  = lastAddr_q;
    count_d     = count_q;
    remain_d    = remain_q;
    word_d      = word_q;
    wSum_d      = wSum_q;
    rSum_d      = rSum_q;
    rxSum_d     = rxSum_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (take && i_rx_dat == SYNC) begin
          err_d     = 1'b0;
          wSum_d    = '0;
          rSum_d    = '0;
          byteIdx_d = '0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (take) begin
          byteIdx_d = byteIdx_q + 2'd1;
          case (byteIdx_q)
            2'd0, 2'd2: lowByte_d = i_rx_dat;
            2'd1: begin
              // Address bits above AW are dropped here.
              startAddr_d = rxWord[AW-1:0];
              ptr_d       = rxWord[AW-1:0];
            end
            default: begin
              count_d   = rxWord;
              remain_d  = rxWord;
              byteIdx_d = '0;
              state_d   = (rxWord == 16'd0) ? SUM : DATA_LO;
            end
          endcase
        end
      end
      DATA_LO: begin
        if (take) begin
          lowByte_d = i_rx_dat;
          state_d   = DATA_HI;
        end
      end
      DATA_HI: begin
        if (take) begin
          word_d  = rxWord;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wSum_d     = wSum_q + word_q;
        lastAddr_d = ptr_q;
        ptr_d      = ptr_q + AW'(1);
        remain_d   = remain_q - 16'd1;
        state_d    = (remain_q == 16'd1) ? SUM : DATA_LO;
      end
      SUM: begin
        if (take) begin
          if (byteIdx_q[0] == 1'b0) begin
            lowByte_d = i_rx_dat;
            byteIdx_d = 2'd1;
          end else begin
            // Rewind to the start of the region for the readback pass.
            rxSum_d   = rxWord;
            ptr_d     = startAddr_q;
            remain_d  = count_q;
            byteIdx_d = '0;
            state_d   = (count_q == 16'd0) ? RESULT : VERIFY;
          end
        end
      end
      VERIFY: begin
        rSum_d     = rSum_q + i_mem_dat;
        lastAddr_d = ptr_q;
        ptr_d      = ptr_q + AW'(1);
        remain_d   = remain_q - 16'd1;
        if (remain_q == 16'd1) state_d = RESULT;
      end
      RESULT: begin
        err_d   = err_q | sumBad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      byteIdx_q   <= '0;
      lowByte_q   <= '0;
      startAddr_q <= '0;
      ptr_q       <= '0;
      lastAddr_q  <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      word_q      <= '0;
      wSum_q      <= '0;
      rSum_q      <= '0;
      rxSum_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteIdx_q   <= byteIdx_d;
      lowByte_q   <= lowByte_d;
      startAddr_q <= startAddr_d;
      ptr_q       <= ptr_d;
      lastAddr_q  <= lastAddr_d;
      count_q     <= count_d;
      remain_q    <= remain_d;
      word_q      <= word_d;
      wSum_q      <= wSum_d;
      rSum_q      <= rSum_d;
      rxSum_q     <= rxSum_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized frame stimulus for mem_loader, checked every
// cycle against a frame-level reference model plus a few literal results.
`timescale 1ns/1ps
module tb_mem_loader;
  localparam int AW    = 12;
  localparam int MEMSZ = 1 << AW;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_DN  = 3;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [7:0]    i_rx_dat;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic          o_mem_cyc;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [15:0]   o_mem_dat;
  logic [15:0]   i_mem_dat;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  always #5 clk = ~clk;

  mem_loader #(.AW(AW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_rx_dat(i_rx_dat), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_mem_cyc(o_mem_cyc), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_dat(o_mem_dat), .i_mem_dat(i_mem_dat),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // Block RAM stand-in with combinational read.
  logic [15:0] mem [MEMSZ];
  assign i_mem_dat = mem[o_mem_addr];

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 16'(i * 7 + 3);
    forever begin
      @(posedge clk);
      if (o_mem_cyc && o_mem_we) mem[o_mem_addr] <= o_mem_dat;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected bus/done events keyed by cycle number.
  int            expKind [int];
  logic [AW-1:0] expAddr [int];
  logic [15:0]   expData [int];
  bit            expErr  [int];
  logic [15:0]   shadow [MEMSZ];

  bit            checkEn = 0;
  int            cycleNo = 0;
  bit            modelBusy = 0;
  bit            modelErr = 0;
  logic [AW-1:0] lastAddr = '0;
  logic [15:0]   lastDat = '0;
  bit            pendReset = 0;
  bit            pendStart = 0;
  int            doneCount = 0;
  int            busCount = 0;
  logic          lastDoneErr = 1'b0;

  bit            frameActive = 0;
  int            pos, frBase, frN;
  logic [7:0]    lowB;
  logic [15:0]   wsum;

  task automatic trackByte(input logic [7:0] b);
    int j, k, c;
    logic [15:0] data, rxs, rb;
    bit e;
    if (!frameActive) begin
      if (b == 8'hA5) begin
        frameActive = 1;
        pos = 0;
        pendStart = 1;
      end
      return;
    end
    pos++;
    if (pos == 1) lowB = b;
    else if (pos == 2) frBase = int'({b, lowB}) % MEMSZ;
    else if (pos == 3) lowB = b;
    else if (pos == 4) begin
      frN = int'({b, lowB});
      wsum = 16'd0;
    end else begin
      j = pos - 5;
      if (j < 2 * frN) begin
        if (j % 2 == 0) lowB = b;
        else begin
          data = {b, lowB};
          c = cycleNo + 1;
          expKind[c] = K_WR;
          expAddr[c] = AW'((frBase + j / 2) % MEMSZ);
          expData[c] = data;
          wsum = wsum + data;
        end
      end else begin
        k = j - 2 * frN;
        if (k == 0) lowB = b;
        else begin
          rxs = {b, lowB};
          rb = 16'd0;
          for (int i = 0; i < frN; i++) begin
            c = cycleNo + 1 + i;
            expKind[c] = K_RD;
            expAddr[c] = AW'((frBase + i) % MEMSZ);
            rb = rb + shadow[(frBase + i) % MEMSZ];
          end
          e = (rxs != wsum) || (rb != wsum);
          c = cycleNo + 1 + frN;
          expKind[c] = K_DN;
          expErr[c] = e;
          frameActive = 0;
        end
      end
    end
  endtask

  task automatic modelCycle();
    int kind;
    cycleNo++;
    if (pendReset) begin
      modelBusy = 0; modelErr = 0; lastAddr = '0; lastDat = '0; pendReset = 0;
    end
    if (pendStart) begin
      modelBusy = 1; modelErr = 0; pendStart = 0;
    end
    if (i_reset) begin
      expKind.delete(); expAddr.delete(); expData.delete(); expErr.delete();
      frameActive = 0;
      pendReset = 1;
      kind = 0;
    end else begin
      kind = expKind.exists(cycleNo) ? expKind[cycleNo] : 0;
    end
    if (kind == K_DN) modelErr = expErr[cycleNo];
    checkOutput("cyc", 32'(o_mem_cyc), 32'(kind == K_WR || kind == K_RD));
    checkOutput("we", 32'(o_mem_we), 32'(kind == K_WR));
    checkOutput("done", 32'(o_done), 32'(kind == K_DN));
    checkOutput("ready", 32'(o_rx_ready), 32'(kind == 0 && !i_reset));
    checkOutput("busy", 32'(o_busy), 32'(modelBusy));
    checkOutput("err", 32'(o_err), 32'(modelErr));
    if (kind == K_WR || kind == K_RD) checkOutput("addr", 32'(o_mem_addr), 32'(expAddr[cycleNo]));
    else checkOutput("addr-hold", 32'(o_mem_addr), 32'(lastAddr));
    if (kind == K_WR) checkOutput("wdata", 32'(o_mem_dat), 32'(expData[cycleNo]));
    else checkOutput("data-hold", 32'(o_mem_dat), 32'(lastDat));
    if (o_mem_cyc) busCount++;
    if (kind == K_WR) begin
      shadow[expAddr[cycleNo]] = expData[cycleNo];
      lastAddr = expAddr[cycleNo];
      lastDat = expData[cycleNo];
    end else if (kind == K_RD) begin
      lastAddr = expAddr[cycleNo];
    end else if (kind == K_DN) begin
      modelBusy = 0;
      doneCount++;
      lastDoneErr = o_err;
    end
    if (kind != 0) begin
      expKind.delete(cycleNo);
      if (expAddr.exists(cycleNo)) expAddr.delete(cycleNo);
      if (expData.exists(cycleNo)) expData.delete(cycleNo);
      if (expErr.exists(cycleNo)) expErr.delete(cycleNo);
    end
    if (i_rx_valid && o_rx_ready) trackByte(i_rx_dat);
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) shadow[i] = 16'(i * 7 + 3);
    forever begin
      @(negedge clk);
      #1;
      if (checkEn) modelCycle();
    end
  end

  // Drives one byte with optional random idle gaps and holds it until taken.
  task automatic applyStimulus(input logic [7:0] b);
    int gaps, waitCnt;
    gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    repeat (gaps) begin
      @(negedge clk);
      i_rx_valid = 1'b0;
      i_rx_dat = 8'($urandom);
    end
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_dat = b;
    waitCnt = 0;
    while (!o_rx_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!o_rx_ready) checkOutput("ready-timeout", 32'(o_rx_ready), 32'd1);
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  logic [15:0] txWords [$];

  task automatic sendFrame(input logic [15:0] base, input logic [15:0] sumXor);
    logic [15:0] s, n16;
    s = 16'd0;
    foreach (txWords[i]) s = s + txWords[i];
    s = s ^ sumXor;
    n16 = 16'(txWords.size());
    applyStimulus(8'hA5);
    applyStimulus(base[7:0]);
    applyStimulus(base[15:8]);
    applyStimulus(n16[7:0]);
    applyStimulus(n16[15:8]);
    foreach (txWords[i]) begin
      applyStimulus(txWords[i][7:0]);
      applyStimulus(txWords[i][15:8]);
    end
    applyStimulus(s[7:0]);
    applyStimulus(s[15:8]);
  endtask

  task automatic waitDone(input int target);
    int t;
    t = 0;
    while (doneCount < target && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    checkOutput("done-count", 32'(doneCount), 32'(target));
  endtask

  initial begin
    int expDones, busBefore, nW;
    logic [15:0] x, w0;
    logic [7:0] g;
    i_reset = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_dat = 8'h00;
    expDones = 0;
    @(negedge clk);
    checkEn = 1;
    @(negedge clk);
    i_reset = 1'b0;

    // Basic two-word frame at 0x010.
    busBefore = busCount;
    txWords = '{16'h1234, 16'hABCD};
    sendFrame(16'h0010, 16'h0000);
    expDones++;
    waitDone(expDones);
    checkOutput("f1-mem010", 32'(mem[12'h010]), 32'h1234);
    checkOutput("f1-mem011", 32'(mem[12'h011]), 32'hABCD);
    checkOutput("f1-err", 32'(lastDoneErr), 32'd0);
    checkOutput("f1-buscycles", 32'(busCount - busBefore), 32'd4);

    // Same frame with a zero checksum: written, but flagged.
    sendFrame(16'h0010, 16'hBE01);
    expDones++;
    waitDone(expDones);
    checkOutput("f2-err", 32'(lastDoneErr), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("f2-sticky", 32'(o_err), 32'd1);

    // Garbage while idle, then a frame that wraps the address space.
    busBefore = busCount;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    repeat (2) @(negedge clk);
    checkOutput("garbage-nobus", 32'(busCount - busBefore), 32'd0);
    checkOutput("garbage-sticky", 32'(o_err), 32'd1);
    txWords = '{16'h0001, 16'h0002};
    sendFrame(16'h0FFF, 16'h0000);
    expDones++;
    waitDone(expDones);
    checkOutput("wrap-memFFF", 32'(mem[12'hFFF]), 32'h0001);
    checkOutput("wrap-mem000", 32'(mem[12'h000]), 32'h0002);
    checkOutput("wrap-err", 32'(lastDoneErr), 32'd0);

    // Empty frame: no bus cycles at all.
    busBefore = busCount;
    txWords.delete();
    sendFrame(16'h0000, 16'h0000);
    expDones++;
    waitDone(expDones);
    checkOutput("n0-nobus", 32'(busCount - busBefore), 32'd0);
    checkOutput("n0-err", 32'(lastDoneErr), 32'd0);

    // Reset after the first write of a three-word frame.
    w0 = 16'($urandom);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(w0[7:0]);
    applyStimulus(w0[15:8]);
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort-nodone", 32'(doneCount), 32'(expDones));
    checkOutput("abort-mem200", 32'(mem[12'h200]), 32'(w0));
    checkOutput("abort-mem201", 32'(mem[12'h201]), 32'h0E0A);
    txWords = '{16'($urandom), 16'($urandom), 16'($urandom)};
    sendFrame(16'h0200, 16'h0000);
    expDones++;
    waitDone(expDones);
    checkOutput("after-abort-err", 32'(lastDoneErr), 32'd0);

    // Randomized frames with garbage, gaps and occasional bad checksums.
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        applyStimulus(g);
      end
      nW = int'($urandom_range(1, 8));
      txWords.delete();
      repeat (nW) txWords.push_back(16'($urandom));
      x = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      sendFrame(16'($urandom), x);
      expDones++;
      waitDone(expDones);
      checkOutput("rand-err", 32'(lastDoneErr), 32'(x != 16'h0000));
    end

    repeat (5) @(negedge clk);
    checkOutput("pending-events", 32'(expKind.num()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
